// File: rtl/zx_tape_pkg.sv
// Shared types and constants for the ZX Spectrum tape decoder.
// Covers FSM states, pulse classes, border colour indices and the default block size.
package zx_tape_pkg;

  localparam int unsigned MemBytesDefault = 6912;

  localparam logic [2:0] ColBlue   = 3'd1;
  localparam logic [2:0] ColRed    = 3'd2;
  localparam logic [2:0] ColCyan   = 3'd5;
  localparam logic [2:0] ColYellow = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StPilot,
    StSync2,
    StDataA,
    StDataB,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    PcGlitch,
    PcSync,
    PcZero,
    PcOne,
    PcPilot,
    PcLong
  } pulse_e;

endpackage

// File: rtl/zx_pulse_classifier.sv
// EAR synchroniser, edge detector and saturating half-period counter.
// Emits a registered edge strobe with the pulse class, or a timeout strobe.
module zx_pulse_classifier
  import zx_tape_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_PULSE = 200,
  parameter int unsigned SYNC_MAX  = 780,
  parameter int unsigned ZERO_MAX  = 1200,
  parameter int unsigned ONE_MAX   = 1900,
  parameter int unsigned PILOT_MAX = 2600,
  parameter int unsigned TIMEOUT   = 60000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ear_i,
  output logic       edge_o,
  output logic [2:0] cls_o,
  output logic       timeout_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             sync0_q, sync1_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_q, edge_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       cls_q;
  pulse_e           cls_d;

  always_comb begin
    edge_d    = sync1_q != prev_q;
    timeout_d = !edge_d && (cnt_q == CNT_W'(TIMEOUT));
    if (edge_d) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (cnt_q < CNT_W'(MIN_PULSE)) begin
      cls_d = PcGlitch;
    end else if (cnt_q <= CNT_W'(SYNC_MAX)) begin
      cls_d = PcSync;
    end else if (cnt_q <= CNT_W'(ZERO_MAX)) begin
      cls_d = PcZero;
    end else if (cnt_q <= CNT_W'(ONE_MAX)) begin
      cls_d = PcOne;
    end else if (cnt_q <= CNT_W'(PILOT_MAX)) begin
      cls_d = PcPilot;
    end else begin
      cls_d = PcLong;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      edge_q    <= 1'b0;
      timeout_q <= 1'b0;
      cls_q     <= 3'd0;
    end else begin
      sync0_q   <= ear_i;
      sync1_q   <= sync0_q;
      prev_q    <= sync1_q;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      timeout_q <= timeout_d;
      cls_q     <= cls_d;
    end
  end

  assign edge_o    = edge_q;
  assign cls_o     = cls_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/zx_tape_decoder.sv
// ZX tape loader: pilot/sync/data pulse FSM feeding the screen-memory write port.
// Define ZX_TAPE_XOR_CHECK_EN to expect a trailing XOR checksum byte and add check_ok.
module zx_tape_decoder
  import zx_tape_pkg::*;
#(
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned MIN_PULSE        = 200,
  parameter int unsigned SYNC_MAX         = 780,
  parameter int unsigned ZERO_MAX         = 1200,
  parameter int unsigned ONE_MAX          = 1900,
  parameter int unsigned PILOT_MAX        = 2600,
  parameter int unsigned PILOT_MIN_PULSES = 256,
  parameter int unsigned TIMEOUT          = 60000,
  parameter int unsigned MEM_BYTES        = MemBytesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ear_in,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [12:0] loading_addr,
  output logic [2:0]  border,
  output logic        busy,
`ifdef ZX_TAPE_XOR_CHECK_EN
  output logic        check_ok,
`endif
  output logic        error
);

  localparam logic [12:0] MemEnd   = 13'(MEM_BYTES);
  localparam logic [15:0] PilotMin = 16'(PILOT_MIN_PULSES);

  logic       pc_edge, pc_timeout;
  logic [2:0] pc_cls_raw;
  pulse_e     pc_cls;

  zx_pulse_classifier #(
    .CNT_W    (CNT_W),
    .MIN_PULSE(MIN_PULSE),
    .SYNC_MAX (SYNC_MAX),
    .ZERO_MAX (ZERO_MAX),
    .ONE_MAX  (ONE_MAX),
    .PILOT_MAX(PILOT_MAX),
    .TIMEOUT  (TIMEOUT)
  ) u_classifier (
    .clk      (clk),
    .rst_n    (rst_n),
    .ear_i    (ear_in),
    .edge_o   (pc_edge),
    .cls_o    (pc_cls_raw),
    .timeout_o(pc_timeout)
  );

  assign pc_cls = pulse_e'(pc_cls_raw);

  state_e      state_q, state_d;
  logic [15:0] pilot_q, pilot_d;
  logic [2:0]  bits_q, bits_d;
  logic [7:0]  shift_q, shift_d;
  logic        half_q, half_d;  // first half of the pending bit was a one
  logic        err_q, err_d;
  logic [12:0] addr_q, addr_d;
  logic [2:0]  border_q, border_d;
  logic        wr_en_q, wr_en_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  byte_next;
`ifdef ZX_TAPE_XOR_CHECK_EN
  logic [7:0]  xor_q, xor_d;
  logic        check_ok_q, check_ok_d;
`endif

  assign byte_next = {shift_q[6:0], half_q};

  always_comb begin
    state_d   = state_q;
    pilot_d   = pilot_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    half_d    = half_q;
    err_d     = err_q;
    addr_d    = addr_q;
    border_d  = border_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef ZX_TAPE_XOR_CHECK_EN
    xor_d      = xor_q;
    check_ok_d = 1'b0;
`endif

    if (pc_edge) begin
      unique case (state_q)
        StIdle: begin
          if (pc_cls == PcPilot) begin
            state_d = StPilot;
            pilot_d = 16'd1;
          end
        end
        StPilot: begin
          if (pc_cls == PcPilot) begin
            if (pilot_q != 16'hFFFF) pilot_d = pilot_q + 16'd1;
          end else if (pc_cls == PcSync && pilot_q >= PilotMin) begin
            state_d = StSync2;
            err_d   = 1'b0;
            addr_d  = '0;
            bits_d  = '0;
`ifdef ZX_TAPE_XOR_CHECK_EN
            xor_d   = '0;
`endif
          end else begin
            state_d = StIdle;
          end
        end
        StSync2: begin
          if (pc_cls == PcSync) begin
            state_d = StDataA;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        StDataA: begin
          if (pc_cls == PcZero || pc_cls == PcOne) begin
            half_d  = pc_cls == PcOne;
            state_d = StDataB;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        StDataB: begin
          if ((pc_cls == PcZero && !half_q) || (pc_cls == PcOne && half_q)) begin
            shift_d = byte_next;
            bits_d  = bits_q + 3'd1;
            state_d = StDataA;
            if (bits_q == 3'd7) begin
`ifdef ZX_TAPE_XOR_CHECK_EN
              if (addr_q == MemEnd) begin
                state_d = StDone;
                if (byte_next == xor_q) check_ok_d = 1'b1;
                else                    err_d      = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = byte_next;
              end
`else
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = byte_next;
`endif
            end
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end else if (pc_timeout && state_q != StIdle) begin
      state_d = StIdle;
      if (state_q != StDone && bits_q != 3'd0) err_d = 1'b1;
    end

    // Address advances the cycle after the strobe; the block ends on the last byte.
    if (wr_en_q) begin
      addr_d = addr_q + 13'd1;
`ifdef ZX_TAPE_XOR_CHECK_EN
      xor_d  = xor_q ^ wr_data_q;
`else
      if (addr_q + 13'd1 == MemEnd) state_d = StDone;
`endif
    end

    if (state_d == StIdle) bits_d = '0;

    if (state_d == StIdle || state_d == StDone) begin
      border_d = 3'd0;
    end else if (pc_edge) begin
      if (state_d == StPilot || state_d == StSync2) begin
        border_d = (border_q == ColRed) ? ColCyan : ColRed;
      end else begin
        border_d = (border_q == ColBlue) ? ColYellow : ColBlue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pilot_q    <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      half_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      border_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef ZX_TAPE_XOR_CHECK_EN
      xor_q      <= '0;
      check_ok_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pilot_q    <= pilot_d;
      bits_q     <= bits_d;
      shift_q    <= shift_d;
      half_q     <= half_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      border_q   <= border_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef ZX_TAPE_XOR_CHECK_EN
      xor_q      <= xor_d;
      check_ok_q <= check_ok_d;
`endif
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign loading_addr = addr_q;
  assign border       = border_q;
  assign busy         = state_q != StIdle;
  assign error        = err_q;
`ifdef ZX_TAPE_XOR_CHECK_EN
  assign check_ok     = check_ok_q;
`endif

endmodule

// File: doc/zx_tape_decoder.md
Name: zx_tape_decoder

Overview:
- Receiver end of the ZX Spectrum tape-loading path: samples the EAR level and measures half-period widths.
- Decodes pilot, sync and data pulses into bytes and writes them sequentially into the 6912-byte screen memory.
- Exports the load address so the display side can reveal screen data progressively.
- Exports the border-stripe colour so the loader visuals track real signal edges.

Parameters:
- CNT_W, 16, width of the half-period counter (saturating).
- MIN_PULSE, 200, half-periods shorter than this are glitches → error.
- SYNC_MAX, 780, upper bound for S class (sync 667/735).
- ZERO_MAX, 1200, upper bound for Z class (nominal 855).
- ONE_MAX, 1900, upper bound for O class (nominal 1710).
- PILOT_MAX, 2600, upper bound for P class (nominal 2168).
- PILOT_MIN_PULSES, 256, consecutive P half-periods required before sync is accepted.
- TIMEOUT, 60000, clocks without an edge that end a block.
- MEM_BYTES, 6912, bytes per block; writes stop at this count.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- ear_in, input, 1, raw tape level, asynchronous to clk.
- wr_en, output, 1, one-cycle write strobe.
- wr_addr, output, 13, screen-memory byte address.
- wr_data, output, 8, decoded byte.
- loading_addr, output, 13, count of bytes written in this block (0..MEM_BYTES).
- border, output, 3, ZX border colour index.
- busy, output, 1, high in any state other than IDLE.
- error, output, 1, sticky; set by a decode fault, cleared on the next pilot detection.

Behaviour:
- Reset: asynchronous, active-low. Clock and reset are fixed: one clock, `clk`; `rst_n` asynchronous active-low.
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-byte discards the partial byte; no write is issued.
- Input sync: ear_in passes through a 2-FF synchroniser; an edge is sync[1] != previous sync value. Edge-to-measurement latency is 3 clocks.
- Half-period counter: increments every clock, saturates at 2^CNT_W-1. On an edge, the counter value is classified, then the counter resets to 1.
- Classification by length L:
  - L < MIN_PULSE → G (glitch)
  - L ≤ SYNC_MAX → S
  - L ≤ ZERO_MAX → Z
  - L ≤ ONE_MAX → O
  - L ≤ PILOT_MAX → P
  - otherwise → L (long)
- States and transitions:
  - IDLE: first P starts PILOT with pilot_cnt=1. Any other class is ignored.
  - PILOT: P increments pilot_cnt (saturating). S with pilot_cnt ≥ PILOT_MIN_PULSES goes to SYNC2; clears error, loading_addr and bit count. S with a short pilot, or any other class, returns to IDLE (no error).
  - SYNC2: S goes to DATA_A. Any other class sets error and goes to IDLE.
  - DATA_A: Z or O records the first half of a bit and goes to DATA_B. Any other class sets error and goes to IDLE.
  - DATA_B: the class must equal the one recorded in DATA_A. Z shifts in 0, O shifts in 1, MSB first. A mismatch or other class sets error and goes to IDLE. Otherwise return to DATA_A.
  - Byte completion: after the 8th bit, next clock: wr_en=1, wr_addr=loading_addr, wr_data=byte; loading_addr increments the cycle after the strobe. When loading_addr reaches MEM_BYTES, go to DONE.
  - DONE: edges are ignored and there are no writes. Return to IDLE once the counter reaches TIMEOUT.
  - Timeout in PILOT, SYNC2, DATA_A or DATA_B: counter == TIMEOUT with no edge returns to IDLE. A partial byte is dropped; error is not set if the bit count is 0, otherwise error is set.
  - If an edge and timeout coincide, the edge wins.
- Border:
  - IDLE/DONE: 0.
  - PILOT/SYNC2: alternates 2/5 (red/cyan), toggling on each edge.
  - DATA_A/DATA_B: alternates 1/6 (blue/yellow), toggling on each edge.
  - Registered; updates 1 clock after the classifying edge.
- wr_addr never exceeds MEM_BYTES-1.

Optional Feature:
- Macro ZX_TAPE_XOR_CHECK_EN.
- Defined: the block runs a byte-wide XOR over all written bytes and receives byte MEM_BYTES+1 as a checksum, which is not written. On mismatch it sets error; on match it pulses wr_en-free `check_ok` for 1 clock on entry to DONE. Adds output port check_ok (1 bit).
- Undefined: no checksum byte, no check_ok port, and DONE is entered directly after byte MEM_BYTES.

Decomposition:
- Shared package zx_tape_pkg: state enum, pulse-class enum, ZX colour-index constants (BLUE=1, RED=2, CYAN=5, YELLOW=6), and MEM_BYTES default.
- One natural sub-module: zx_pulse_classifier, containing synchroniser, edge detect, saturating counter and classification. It outputs edge strobe, class and timeout. The FSM and write port stay in the top of the block.

Test Plan:
- Pilot, sync, data: 300 pilot half-periods of 2168, sync 667/735, then byte 0xA5 as pulse pairs → wr_en once, wr_addr=0, wr_data=0xA5, loading_addr=1, error=0.
- Short pilot: 100 pilot half-periods then sync → returns to IDLE, no writes, error=0.
- Pair mismatch: after a valid sync, pulses 855 then 1710 → error=1, state IDLE, no write. A following valid 300-pilot block clears error.
- Full block: 6912 bytes with pattern addr[7:0] → last write at addr 6911, loading_addr=6912, state DONE. Extra pulses produce no writes; IDLE after 60000 quiet clocks.
- Reset mid-operation: rst_n low after 3 bits of byte 5 → all outputs 0 immediately, no write. Restarting a block writes from addr 0.
- Glitch and timeout: a 150-clock half-period in DATA_A → error=1. Separately, an edge stall of 60000 clocks with 4 bits pending → IDLE, error=1.
